// File: rtl/mem_stage_pkg.sv
// Shared encodings for the memory-access stage: bus op and size codes, FSM states.
// Purely declarative; no logic, no latency, no flow control.
package mem_stage_pkg;

   localparam int XLEN = 64;

   localparam logic [1:0] MEM_NONE  = 2'b00;
   localparam logic [1:0] MEM_LOAD  = 2'b01;
   localparam logic [1:0] MEM_STORE = 2'b10;
   localparam logic [1:0] MEM_RSVD  = 2'b11;

   localparam logic [1:0] SIZE_B = 2'b00;
   localparam logic [1:0] SIZE_H = 2'b01;
   localparam logic [1:0] SIZE_W = 2'b10;
   localparam logic [1:0] SIZE_D = 2'b11;

   localparam logic [1:0] S_IDLE = 2'b00;
   localparam logic [1:0] S_REQ  = 2'b01;
   localparam logic [1:0] S_RESP = 2'b10;
   localparam logic [1:0] S_DONE = 2'b11;

   // Reserved op code behaves as a plain pass-through instruction.
   function automatic logic is_mem_op(input logic [1:0] op);
      return (op == MEM_LOAD) || (op == MEM_STORE);
   endfunction

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Lane steering for the data bus: store byte-enables/data shift, load extract/extend, misalign flag.
// Purely combinational, zero latency; no flow control.
module lsu_align
   import mem_stage_pkg::*;
(
   input  logic [2:0]      offset,
   input  logic [1:0]      size,
   input  logic            is_unsigned,
   input  logic [XLEN-1:0] store_data,
   input  logic [XLEN-1:0] load_data,
   output logic [7:0]      be,
   output logic [XLEN-1:0] wdata,
   output logic [XLEN-1:0] rdata,
   output logic            misalign
);

   logic [5:0]      bit_shift;
   logic [XLEN-1:0] ld_shifted;
   logic [7:0]      size_mask;

   assign bit_shift  = {offset, 3'b000};
   assign ld_shifted = load_data >> bit_shift;
   assign wdata      = store_data << bit_shift;
   assign be         = size_mask << offset;

   always_comb begin
      size_mask = 8'hFF;
      misalign  = 1'b0;
      rdata     = ld_shifted;
      case (size)
         SIZE_B: begin
            size_mask = 8'h01;
            rdata = is_unsigned ? {{(XLEN-8){1'b0}}, ld_shifted[7:0]}
                                : {{(XLEN-8){ld_shifted[7]}}, ld_shifted[7:0]};
         end
         SIZE_H: begin
            size_mask = 8'h03;
            misalign  = offset[0];
            rdata = is_unsigned ? {{(XLEN-16){1'b0}}, ld_shifted[15:0]}
                                : {{(XLEN-16){ld_shifted[15]}}, ld_shifted[15:0]};
         end
         SIZE_W: begin
            size_mask = 8'h0F;
            misalign  = |offset[1:0];
            rdata = is_unsigned ? {{(XLEN-32){1'b0}}, ld_shifted[31:0]}
                                : {{(XLEN-32){ld_shifted[31]}}, ld_shifted[31:0]};
         end
         default: begin
            size_mask = 8'hFF;
            misalign  = |offset;
            rdata     = ld_shifted;
         end
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// RV64 memory stage: ALU/CSR results retire in 1 cycle; loads/stores run req/gnt/rvalid (store >=2, load >=3 cycles).
// stall_i freezes the output registers only; busy_o holds upstream while a bus access is pending.
module mem_stage
   import mem_stage_pkg::*;
(
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            stall_i,
   input  logic            flush_i,
   input  logic            valid_i,
   input  logic [4:0]      rd_addr_i,
   input  logic            rd_we_i,
   input  logic [XLEN-1:0] rd_data_i,
   input  logic [1:0]      mem_op_i,
   input  logic [1:0]      mem_size_i,
   input  logic            mem_unsigned_i,
   input  logic [XLEN-1:0] store_data_i,
   input  logic [11:0]     csr_addr_i,
   input  logic [XLEN-1:0] csr_data_i,
   input  logic            csr_we_i,
   output logic            dmem_req_o,
   output logic            dmem_we_o,
   output logic [XLEN-1:0] dmem_addr_o,
   output logic [XLEN-1:0] dmem_wdata_o,
   output logic [7:0]      dmem_be_o,
   input  logic            dmem_gnt_i,
   input  logic            dmem_rvalid_i,
   input  logic [XLEN-1:0] dmem_rdata_i,
   output logic            valid_o,
   output logic [4:0]      rd_addr_o,
   output logic [XLEN-1:0] rd_data_o,
   output logic            rd_we_o,
   output logic [11:0]     csr_addr_o,
   output logic [XLEN-1:0] csr_data_o,
   output logic            csr_we_o,
   output logic            misalign_o,
   output logic            busy_o,
   output logic [4:0]      fwdrd_addr_o,
   output logic [XLEN-1:0] fwdrd_data_o
);

   logic [1:0]      state_q;
   logic            req_q;
   logic            kill_q;
   logic            op_store_q;
   logic            op_unsigned_q;
   logic            op_rd_we_q;
   logic [1:0]      op_size_q;
   logic [2:0]      op_offset_q;
   logic [4:0]      op_rd_addr_q;
   logic [7:0]      op_be_q;
   logic [XLEN-1:0] op_addr_q;
   logic [XLEN-1:0] op_wdata_q;
   logic [XLEN-1:0] op_data_q;

   logic            idle;
   logic            in_mem;
   logic            in_aligned_mem;
   logic            killed;
   logic [2:0]      al_offset;
   logic [1:0]      al_size;
   logic            al_unsigned;
   logic [7:0]      al_be;
   logic [XLEN-1:0] al_wdata;
   logic [XLEN-1:0] al_rdata;
   logic            al_misalign;

   assign idle   = (state_q == S_IDLE);
   assign in_mem = valid_i && is_mem_op(mem_op_i);
   assign killed = kill_q || flush_i;

   // In IDLE the aligner sees the incoming op; afterwards it works on the latched op for load data.
   assign al_offset   = idle ? rd_data_i[2:0] : op_offset_q;
   assign al_size     = idle ? mem_size_i     : op_size_q;
   assign al_unsigned = idle ? mem_unsigned_i : op_unsigned_q;

   lsu_align u_align (
      .offset      (al_offset),
      .size        (al_size),
      .is_unsigned (al_unsigned),
      .store_data  (store_data_i),
      .load_data   (dmem_rdata_i),
      .be          (al_be),
      .wdata       (al_wdata),
      .rdata       (al_rdata),
      .misalign    (al_misalign)
   );

   assign in_aligned_mem = in_mem && !al_misalign;
   assign busy_o         = !idle || in_aligned_mem;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= S_IDLE;
         req_q         <= 1'b0;
         kill_q        <= 1'b0;
         op_store_q    <= 1'b0;
         op_unsigned_q <= 1'b0;
         op_rd_we_q    <= 1'b0;
         op_size_q     <= 2'b00;
         op_offset_q   <= 3'b000;
         op_rd_addr_q  <= 5'd0;
         op_be_q       <= 8'h00;
         op_addr_q     <= '0;
         op_wdata_q    <= '0;
         op_data_q     <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_aligned_mem && !flush_i) begin
                  state_q       <= S_REQ;
                  req_q         <= 1'b1;
                  kill_q        <= 1'b0;
                  op_store_q    <= (mem_op_i == MEM_STORE);
                  op_unsigned_q <= mem_unsigned_i;
                  op_rd_we_q    <= rd_we_i;
                  op_size_q     <= mem_size_i;
                  op_offset_q   <= rd_data_i[2:0];
                  op_rd_addr_q  <= rd_addr_i;
                  op_be_q       <= al_be;
                  op_addr_q     <= {rd_data_i[XLEN-1:3], 3'b000};
                  op_wdata_q    <= al_wdata;
                  op_data_q     <= rd_data_i;
               end
            end
            S_REQ: begin
               // Once granted the access is committed; a coincident flush only suppresses retirement.
               if (dmem_gnt_i) begin
                  req_q   <= 1'b0;
                  kill_q  <= flush_i;
                  state_q <= op_store_q ? S_DONE : S_RESP;
               end else if (flush_i) begin
                  req_q   <= 1'b0;
                  state_q <= S_IDLE;
               end
            end
            S_RESP: begin
               if (flush_i) kill_q <= 1'b1;
               if (dmem_rvalid_i) begin
                  op_data_q <= al_rdata;
                  state_q   <= S_DONE;
               end
            end
            default: begin
               if (flush_i) kill_q <= 1'b1;
               if (!stall_i) state_q <= S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_o    <= 1'b0;
         rd_addr_o  <= 5'd0;
         rd_data_o  <= '0;
         rd_we_o    <= 1'b0;
         csr_addr_o <= 12'd0;
         csr_data_o <= '0;
         csr_we_o   <= 1'b0;
         misalign_o <= 1'b0;
      end else if (!stall_i) begin
         if (state_q == S_DONE) begin
            valid_o    <= !killed;
            rd_addr_o  <= op_rd_addr_q;
            rd_data_o  <= op_data_q;
            rd_we_o    <= op_rd_we_q && !op_store_q && !killed;
            csr_we_o   <= 1'b0;
            misalign_o <= 1'b0;
         end else if (idle && valid_i && !flush_i && !in_aligned_mem) begin
            // Pass-through op, or a misaligned access retiring without touching the bus.
            valid_o    <= 1'b1;
            rd_addr_o  <= rd_addr_i;
            rd_data_o  <= rd_data_i;
            rd_we_o    <= rd_we_i && !in_mem;
            csr_addr_o <= csr_addr_i;
            csr_data_o <= csr_data_i;
            csr_we_o   <= csr_we_i && !in_mem;
            misalign_o <= in_mem;
         end else begin
            valid_o    <= 1'b0;
            rd_we_o    <= 1'b0;
            csr_we_o   <= 1'b0;
            misalign_o <= 1'b0;
         end
      end
   end

   assign dmem_req_o   = req_q;
   assign dmem_we_o    = op_store_q;
   assign dmem_addr_o  = op_addr_q;
   assign dmem_wdata_o = op_wdata_q;
   assign dmem_be_o    = op_be_q;

   assign fwdrd_addr_o = rd_we_o ? rd_addr_o : 5'd0;
   assign fwdrd_data_o = rd_data_o;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: vector table of single loads/stores plus hand sequences
// for wait states, stall parking, flush in REQ and reset in RESP.
module tb_mem_stage;
   import mem_stage_pkg::*;

   logic            clk_i = 1'b0;
   logic            rst_ni;
   logic            stall_i, flush_i, valid_i;
   logic [4:0]      rd_addr_i;
   logic            rd_we_i;
   logic [63:0]     rd_data_i;
   logic [1:0]      mem_op_i, mem_size_i;
   logic            mem_unsigned_i;
   logic [63:0]     store_data_i;
   logic [11:0]     csr_addr_i;
   logic [63:0]     csr_data_i;
   logic            csr_we_i;
   logic            dmem_req_o, dmem_we_o;
   logic [63:0]     dmem_addr_o, dmem_wdata_o;
   logic [7:0]      dmem_be_o;
   logic            dmem_gnt_i, dmem_rvalid_i;
   logic [63:0]     dmem_rdata_i;
   logic            valid_o;
   logic [4:0]      rd_addr_o;
   logic [63:0]     rd_data_o;
   logic            rd_we_o;
   logic [11:0]     csr_addr_o;
   logic [63:0]     csr_data_o;
   logic            csr_we_o;
   logic            misalign_o, busy_o;
   logic [4:0]      fwdrd_addr_o;
   logic [63:0]     fwdrd_data_o;

   int total;
   int bad;

   always #5 clk_i = ~clk_i;

   mem_stage dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
      .rd_addr_i(rd_addr_i), .rd_we_i(rd_we_i), .rd_data_i(rd_data_i),
      .mem_op_i(mem_op_i), .mem_size_i(mem_size_i), .mem_unsigned_i(mem_unsigned_i),
      .store_data_i(store_data_i), .csr_addr_i(csr_addr_i), .csr_data_i(csr_data_i), .csr_we_i(csr_we_i),
      .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
      .dmem_wdata_o(dmem_wdata_o), .dmem_be_o(dmem_be_o), .dmem_gnt_i(dmem_gnt_i),
      .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
      .valid_o(valid_o), .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o), .rd_we_o(rd_we_o),
      .csr_addr_o(csr_addr_o), .csr_data_o(csr_data_o), .csr_we_o(csr_we_o),
      .misalign_o(misalign_o), .busy_o(busy_o),
      .fwdrd_addr_o(fwdrd_addr_o), .fwdrd_data_o(fwdrd_data_o)
   );

   typedef struct {
      logic [1:0]  op;
      logic [1:0]  sz;
      logic        uns;
      logic [63:0] addr;
      logic [63:0] sdata;
      logic [63:0] rdata;
      logic [7:0]  be;
      logic [63:0] wdata;
      logic [63:0] ldata;
      logic        rd_we;
      logic        mis;
   } vec_t;

   vec_t vecs[13];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total = total + 1;
      if (act !== exp) begin
         bad = bad + 1;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle_inputs();
      valid_i = 1'b0; mem_op_i = MEM_NONE; rd_we_i = 1'b0; csr_we_i = 1'b0;
      flush_i = 1'b0; dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
   endtask

   task automatic alu_op(input logic [4:0] rd, input logic [63:0] data);
      valid_i = 1'b1; mem_op_i = MEM_NONE; rd_addr_i = rd; rd_data_i = data; rd_we_i = 1'b1;
      tick();
      idle_inputs();
   endtask

   // Runs one load/store with gw cycles of no-grant and rw cycles of no-rvalid; returns after retirement.
   task automatic do_mem(input logic [1:0] op, input logic [1:0] sz, input logic uns,
                         input logic [63:0] addr, input logic [63:0] sdata, input logic [63:0] rdata,
                         input logic [4:0] rd, input int gw, input int rw,
                         output logic req_seen, output logic [7:0] be, output logic [63:0] wd,
                         output logic [63:0] da, output logic we, output int busy_n);
      req_seen = 1'b0; be = '0; wd = '0; da = '0; we = 1'b0; busy_n = 0;
      valid_i = 1'b1; mem_op_i = op; mem_size_i = sz; mem_unsigned_i = uns;
      rd_data_i = addr; store_data_i = sdata; rd_addr_i = rd; rd_we_i = (op == MEM_LOAD);
      tick();
      idle_inputs();
      if (!dmem_req_o) return;
      req_seen = 1'b1;
      da = dmem_addr_o;
      for (int k = 0; k < gw; k++) begin
         busy_n = busy_n + int'(busy_o);
         tick();
         chk("req_hold", 64'(dmem_req_o), 64'd1);
         chk("addr_hold", dmem_addr_o, da);
      end
      be = dmem_be_o; wd = dmem_wdata_o; we = dmem_we_o;
      dmem_gnt_i = 1'b1;
      busy_n = busy_n + int'(busy_o);
      tick();
      dmem_gnt_i = 1'b0;
      if (op == MEM_LOAD) begin
         for (int k = 0; k < rw; k++) begin
            busy_n = busy_n + int'(busy_o);
            tick();
         end
         dmem_rvalid_i = 1'b1; dmem_rdata_i = rdata;
         busy_n = busy_n + int'(busy_o);
         tick();
         dmem_rvalid_i = 1'b0;
      end
      busy_n = busy_n + int'(busy_o);
      tick();
   endtask

   logic        r_req, r_we;
   logic [7:0]  r_be;
   logic [63:0] r_wd, r_da;
   int          r_busy;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      total = 0; bad = 0;
      vecs[0]  = '{MEM_STORE, SIZE_B, 1'b0, 64'h1003, 64'hAB, 64'h0, 8'h08, 64'h0000_0000_AB00_0000, 64'h0, 1'b0, 1'b0};
      vecs[1]  = '{MEM_STORE, SIZE_H, 1'b0, 64'h1006, 64'h1234_5678, 64'h0, 8'hC0, 64'h5678_0000_0000_0000, 64'h0, 1'b0, 1'b0};
      vecs[2]  = '{MEM_STORE, SIZE_W, 1'b0, 64'h1004, 64'hDEAD_BEEF, 64'h0, 8'hF0, 64'hDEAD_BEEF_0000_0000, 64'h0, 1'b0, 1'b0};
      vecs[3]  = '{MEM_STORE, SIZE_D, 1'b0, 64'h1008, 64'h0123_4567_89AB_CDEF, 64'h0, 8'hFF, 64'h0123_4567_89AB_CDEF, 64'h0, 1'b0, 1'b0};
      vecs[4]  = '{MEM_LOAD, SIZE_B, 1'b0, 64'h2005, 64'h0, 64'h0000_9A00_0000_0000, 8'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FF9A, 1'b1, 1'b0};
      vecs[5]  = '{MEM_LOAD, SIZE_B, 1'b1, 64'h2005, 64'h0, 64'h0000_9A00_0000_0000, 8'h0, 64'h0, 64'h0000_0000_0000_009A, 1'b1, 1'b0};
      vecs[6]  = '{MEM_LOAD, SIZE_W, 1'b0, 64'h2004, 64'h0, 64'h8765_4321_0000_0000, 8'h0, 64'h0, 64'hFFFF_FFFF_8765_4321, 1'b1, 1'b0};
      vecs[7]  = '{MEM_LOAD, SIZE_W, 1'b1, 64'h2004, 64'h0, 64'h8765_4321_0000_0000, 8'h0, 64'h0, 64'h0000_0000_8765_4321, 1'b1, 1'b0};
      vecs[8]  = '{MEM_LOAD, SIZE_D, 1'b0, 64'h2000, 64'h0, 64'hFEDC_BA98_7654_3210, 8'h0, 64'h0, 64'hFEDC_BA98_7654_3210, 1'b1, 1'b0};
      vecs[9]  = '{MEM_LOAD, SIZE_H, 1'b0, 64'h2006, 64'h0, 64'h7FFF_0000_0000_0000, 8'h0, 64'h0, 64'h0000_0000_0000_7FFF, 1'b1, 1'b0};
      vecs[10] = '{MEM_LOAD, SIZE_W, 1'b0, 64'h3002, 64'h0, 64'h0, 8'h0, 64'h0, 64'h0, 1'b0, 1'b1};
      vecs[11] = '{MEM_STORE, SIZE_H, 1'b0, 64'h1001, 64'h55, 64'h0, 8'h0, 64'h0, 64'h0, 1'b0, 1'b1};
      vecs[12] = '{MEM_LOAD, SIZE_D, 1'b0, 64'h2004, 64'h0, 64'h0, 8'h0, 64'h0, 64'h0, 1'b0, 1'b1};

      rst_ni = 1'b0; stall_i = 1'b0; idle_inputs();
      rd_addr_i = '0; rd_data_i = '0; mem_size_i = '0; mem_unsigned_i = 1'b0;
      store_data_i = '0; csr_addr_i = '0; csr_data_i = '0; dmem_rdata_i = '0;
      repeat (2) @(posedge clk_i);
      #1;
      chk("rst_valid", 64'(valid_o), 64'd0);
      chk("rst_req", 64'(dmem_req_o), 64'd0);
      chk("rst_rd_data", rd_data_o, 64'd0);
      chk("rst_busy", 64'(busy_o), 64'd0);
      rst_ni = 1'b1;
      tick();

      // ALU pass-through with CSR write set.
      valid_i = 1'b1; mem_op_i = MEM_NONE; rd_addr_i = 5'd5; rd_data_i = 64'h1234; rd_we_i = 1'b1;
      csr_addr_i = 12'h300; csr_data_i = 64'h55; csr_we_i = 1'b1;
      #1 chk("alu_busy", 64'(busy_o), 64'd0);
      tick();
      idle_inputs();
      chk("alu_rd_addr", 64'(rd_addr_o), 64'd5);
      chk("alu_rd_data", rd_data_o, 64'h1234);
      chk("alu_fwd_addr", 64'(fwdrd_addr_o), 64'd5);
      chk("alu_fwd_data", fwdrd_data_o, 64'h1234);
      chk("alu_valid", 64'(valid_o), 64'd1);
      chk("alu_csr_addr", 64'(csr_addr_o), 64'h300);
      chk("alu_csr_we", 64'(csr_we_o), 64'd1);
      tick();
      chk("bubble_valid", 64'(valid_o), 64'd0);
      chk("bubble_fwd_addr", 64'(fwdrd_addr_o), 64'd0);

      // Reserved op code is a plain pass-through.
      valid_i = 1'b1; mem_op_i = MEM_RSVD; rd_addr_i = 5'd9; rd_data_i = 64'h99; rd_we_i = 1'b1;
      tick();
      idle_inputs();
      chk("rsvd_rd_data", rd_data_o, 64'h99);
      chk("rsvd_rd_we", 64'(rd_we_o), 64'd1);
      chk("rsvd_no_req", 64'(dmem_req_o), 64'd0);

      // Flush in IDLE drops the incoming instruction.
      valid_i = 1'b1; mem_op_i = MEM_NONE; rd_addr_i = 5'd3; rd_data_i = 64'h33; rd_we_i = 1'b1; flush_i = 1'b1;
      tick();
      idle_inputs();
      chk("idle_flush_valid", 64'(valid_o), 64'd0);
      chk("idle_flush_we", 64'(rd_we_o), 64'd0);

      for (int i = 0; i < 13; i++) begin
         do_mem(vecs[i].op, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].sdata, vecs[i].rdata,
                5'(i + 1), 0, 0, r_req, r_be, r_wd, r_da, r_we, r_busy);
         chk($sformatf("v%0d_req", i), 64'(r_req), 64'(!vecs[i].mis));
         chk($sformatf("v%0d_misalign", i), 64'(misalign_o), 64'(vecs[i].mis));
         chk($sformatf("v%0d_valid", i), 64'(valid_o), 64'd1);
         chk($sformatf("v%0d_rd_we", i), 64'(rd_we_o), 64'(vecs[i].rd_we));
         if (!vecs[i].mis) begin
            chk($sformatf("v%0d_addr", i), r_da, vecs[i].addr & ~64'h7);
            chk($sformatf("v%0d_we", i), 64'(r_we), 64'(vecs[i].op == MEM_STORE));
            chk($sformatf("v%0d_busy", i), 64'(r_busy), (vecs[i].op == MEM_STORE) ? 64'd2 : 64'd3);
            if (vecs[i].op == MEM_STORE) begin
               chk($sformatf("v%0d_be", i), 64'(r_be), 64'(vecs[i].be));
               chk($sformatf("v%0d_wdata", i), r_wd, vecs[i].wdata);
            end else begin
               chk($sformatf("v%0d_rd_data", i), rd_data_o, vecs[i].ldata);
               chk($sformatf("v%0d_rd_addr", i), 64'(rd_addr_o), 64'(i + 1));
            end
         end
      end

      // LH with two grant wait states, signed then unsigned.
      do_mem(MEM_LOAD, SIZE_H, 1'b0, 64'h2002, 64'h0, 64'h0000_0000_8001_0000, 5'd10, 2, 0,
             r_req, r_be, r_wd, r_da, r_we, r_busy);
      chk("lh_wait_signed", rd_data_o, 64'hFFFF_FFFF_FFFF_8001);
      chk("lh_wait_busy", 64'(r_busy), 64'd5);
      do_mem(MEM_LOAD, SIZE_H, 1'b1, 64'h2002, 64'h0, 64'h0000_0000_8001_0000, 5'd10, 2, 1,
             r_req, r_be, r_wd, r_da, r_we, r_busy);
      chk("lh_wait_unsigned", rd_data_o, 64'h0000_0000_0000_8001);
      chk("lh_wait_rv_busy", 64'(r_busy), 64'd6);

      // Load completing under stall parks in DONE while outputs hold.
      alu_op(5'd7, 64'h77);
      valid_i = 1'b1; mem_op_i = MEM_LOAD; mem_size_i = SIZE_D; mem_unsigned_i = 1'b0;
      rd_data_i = 64'h2000; rd_addr_i = 5'd8; rd_we_i = 1'b1; stall_i = 1'b1;
      tick();
      idle_inputs();
      chk("stall_req", 64'(dmem_req_o), 64'd1);
      dmem_gnt_i = 1'b1;
      tick();
      dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = 64'h1122_3344_5566_7788;
      tick();
      dmem_rvalid_i = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk("stall_hold_data", rd_data_o, 64'h77);
         chk("stall_hold_valid", 64'(valid_o), 64'd1);
         chk("stall_busy", 64'(busy_o), 64'd1);
         if (k < 3) tick();
      end
      stall_i = 1'b0;
      tick();
      chk("stall_release_data", rd_data_o, 64'h1122_3344_5566_7788);
      chk("stall_release_addr", 64'(rd_addr_o), 64'd8);
      chk("stall_release_fwd", 64'(fwdrd_addr_o), 64'd8);
      tick();
      chk("stall_after_busy", 64'(busy_o), 64'd0);

      // Flush while waiting for grant drops the request with no write.
      valid_i = 1'b1; mem_op_i = MEM_LOAD; mem_size_i = SIZE_D; rd_data_i = 64'h2008; rd_addr_i = 5'd4; rd_we_i = 1'b1;
      tick();
      idle_inputs();
      chk("flush_req_up", 64'(dmem_req_o), 64'd1);
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      chk("flush_req_drop", 64'(dmem_req_o), 64'd0);
      chk("flush_busy", 64'(busy_o), 64'd0);
      tick();
      chk("flush_no_valid", 64'(valid_o), 64'd0);
      chk("flush_no_we", 64'(rd_we_o), 64'd0);

      // Reset during RESP clears everything and ignores a late rvalid.
      valid_i = 1'b1; mem_op_i = MEM_LOAD; mem_size_i = SIZE_D; rd_data_i = 64'h2010; rd_addr_i = 5'd2; rd_we_i = 1'b1;
      tick();
      idle_inputs();
      dmem_gnt_i = 1'b1;
      tick();
      dmem_gnt_i = 1'b0;
      chk("resp_busy", 64'(busy_o), 64'd1);
      rst_ni = 1'b0;
      #2;
      chk("rst_resp_valid", 64'(valid_o), 64'd0);
      chk("rst_resp_data", rd_data_o, 64'd0);
      chk("rst_resp_busy", 64'(busy_o), 64'd0);
      chk("rst_resp_req", 64'(dmem_req_o), 64'd0);
      rst_ni = 1'b1;
      dmem_rvalid_i = 1'b1; dmem_rdata_i = 64'hDEAD;
      tick();
      dmem_rvalid_i = 1'b0;
      chk("late_rvalid_busy", 64'(busy_o), 64'd0);
      tick();
      chk("late_rvalid_valid", 64'(valid_o), 64'd0);
      chk("late_rvalid_data", rd_data_o, 64'd0);
      alu_op(5'd1, 64'hAA);
      chk("post_rst_alu", rd_data_o, 64'hAA);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
